// File: rtl/ili9341_spi_receiver_pkg.sv
// Shared constants, command codes and decoder state encoding for the ILI9341 SPI receiver.
package ili9341_pkg;

  localparam int unsigned COORD_W        = 9;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned DEF_H_RES      = 240;
  localparam int unsigned DEF_V_RES      = 320;
  localparam int unsigned DEF_PIXEL_SIZE = 16;

  // Default window starts; ends derive from the panel resolution.
  localparam logic [COORD_W-1:0] DEF_SC = '0;
  localparam logic [COORD_W-1:0] DEF_SP = '0;

  localparam logic [BYTE_W-1:0] CMD_SWRESET = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_CASET   = 8'h2A;
  localparam logic [BYTE_W-1:0] CMD_PASET   = 8'h2B;
  localparam logic [BYTE_W-1:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET_ARG,
    ST_PASET_ARG,
    ST_RAMWR_DATA,
    ST_SKIP
  } dec_state_t;

  // A window is illegal when it is inverted or reaches past the panel edge.
  function automatic logic win_bad(input logic [15:0] start, input logic [15:0] stop,
                                   input int unsigned lim);
    return (start > stop) || (32'(stop) >= lim);
  endfunction

endpackage

// File: rtl/ili9341_spi_receiver_if.sv
// SPI input lines and decoded command/pixel outputs of the receiver.
interface ili9341_spi_receiver_if #(
  parameter int unsigned PIXEL_SIZE = 16
);
  import ili9341_pkg::*;

  logic                  spi_sck;
  logic                  spi_mosi;
  logic                  spi_cs;
  logic                  spi_dc;
  logic                  cmd_valid;
  logic [BYTE_W-1:0]     cmd_byte;
  logic                  pixel_valid;
  logic [COORD_W-1:0]    pixel_x;
  logic [COORD_W-1:0]    pixel_y;
  logic [PIXEL_SIZE-1:0] pixel_data;
  logic                  frame_done;
  logic                  err;

  modport master (
    output spi_sck, spi_mosi, spi_cs, spi_dc,
    input  cmd_valid, cmd_byte, pixel_valid, pixel_x, pixel_y, pixel_data, frame_done, err
  );

  modport slave (
    input  spi_sck, spi_mosi, spi_cs, spi_dc,
    output cmd_valid, cmd_byte, pixel_valid, pixel_x, pixel_y, pixel_data, frame_done, err
  );

endinterface

// File: rtl/ili9341_spi_byte_rx.sv
// Synchronizes the SPI lines into clk and assembles MSB-first bytes on sck rising edges.
module ili9341_spi_byte_rx
  import ili9341_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              mosi,
  input  logic              cs,
  input  logic              dc,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_dc,
  output logic              cs_idle
);

  logic [1:0]        sck_s;
  logic [1:0]        mosi_s;
  logic [1:0]        cs_s;
  logic [1:0]        dc_s;
  logic              sck_d;
  logic [BYTE_W-2:0] shreg;
  logic [2:0]        bit_cnt;
  logic              sck_rise;

  assign sck_rise = sck_s[1] & ~sck_d;
  assign cs_idle  = cs_s[1];

  // Two-flop synchronizers, sck edge detect and byte shift register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_s      <= '0;
      mosi_s     <= '0;
      cs_s       <= '0;
      dc_s       <= '0;
      sck_d      <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      sck_s      <= {sck_s[0], sck};
      mosi_s     <= {mosi_s[0], mosi};
      cs_s       <= {cs_s[0], cs};
      dc_s       <= {dc_s[0], dc};
      sck_d      <= sck_s[1];
      byte_valid <= 1'b0;
      if (cs_s[1]) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shreg   <= {shreg[BYTE_W-3:0], mosi_s[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shreg, mosi_s[1]};
          byte_dc    <= dc_s[1];
        end
      end
    end
  end

endmodule

// File: rtl/ili9341_spi_receiver.sv
// ILI9341 SPI stream decoder: command parsing, address window and pixel cursor.
module ili9341_spi_receiver
  import ili9341_pkg::*;
#(
  parameter int unsigned H_RES      = DEF_H_RES,
  parameter int unsigned V_RES      = DEF_V_RES,
  parameter int unsigned PIXEL_SIZE = DEF_PIXEL_SIZE
)(
  input  logic                    clk,
  input  logic                    rst,
  ili9341_spi_receiver_if.slave   bus
);

  localparam logic [COORD_W-1:0] DEF_EC = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] DEF_EP = COORD_W'(V_RES - 1);

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_dc;
  logic              cs_idle;

  dec_state_t         state;
  logic [1:0]         arg_idx;
  logic [23:0]        arg_buf;
  logic [COORD_W-1:0] sc, ec, sp, ep;
  logic [COORD_W-1:0] cx, cy;
  logic [BYTE_W-1:0]  hi_byte;
  logic               have_hi;

  logic                  cmd_valid;
  logic [BYTE_W-1:0]     cmd_byte;
  logic                  pixel_valid;
  logic [COORD_W-1:0]    pixel_x;
  logic [COORD_W-1:0]    pixel_y;
  logic [PIXEL_SIZE-1:0] pixel_data;
  logic                  frame_done;
  logic                  err;

  logic [15:0] arg_start_c;
  logic [15:0] arg_end_c;
  logic        col_bad_c;
  logic        row_bad_c;

  ili9341_spi_byte_rx u_byte_rx (
    .clk        (clk),
    .rst        (rst),
    .sck        (bus.spi_sck),
    .mosi       (bus.spi_mosi),
    .cs         (bus.spi_cs),
    .dc         (bus.spi_dc),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc),
    .cs_idle    (cs_idle)
  );

  // Window bounds formed from the three buffered argument bytes plus the arriving one.
  assign arg_start_c = arg_buf[23:8];
  assign arg_end_c   = {arg_buf[7:0], byte_data};
  assign col_bad_c   = win_bad(arg_start_c, arg_end_c, H_RES);
  assign row_bad_c   = win_bad(arg_start_c, arg_end_c, V_RES);

  // Decoder FSM, window registers, cursor and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      arg_idx     <= '0;
      arg_buf     <= '0;
      sc          <= DEF_SC;
      ec          <= DEF_EC;
      sp          <= DEF_SP;
      ep          <= DEF_EP;
      cx          <= '0;
      cy          <= '0;
      hi_byte     <= '0;
      have_hi     <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_byte    <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_data  <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      // A deselect between the two pixel bytes drops the pending high byte.
      if (cs_idle) have_hi <= 1'b0;
      if (byte_valid) begin
        if (!byte_dc) begin
          cmd_valid <= 1'b1;
          cmd_byte  <= byte_data;
          arg_idx   <= '0;
          have_hi   <= 1'b0;
          case (byte_data)
            CMD_CASET: state <= ST_CASET_ARG;
            CMD_PASET: state <= ST_PASET_ARG;
            CMD_RAMWR: begin
              state <= ST_RAMWR_DATA;
              cx    <= sc;
              cy    <= sp;
            end
            CMD_SWRESET: begin
              state <= ST_IDLE;
              sc    <= DEF_SC;
              ec    <= DEF_EC;
              sp    <= DEF_SP;
              ep    <= DEF_EP;
              err   <= 1'b0;
            end
            default: state <= ST_SKIP;
          endcase
        end else begin
          case (state)
            ST_CASET_ARG, ST_PASET_ARG: begin
              arg_buf <= {arg_buf[15:0], byte_data};
              arg_idx <= arg_idx + 2'd1;
              if (arg_idx == 2'd3) begin
                state <= ST_IDLE;
                if (state == ST_CASET_ARG) begin
                  if (col_bad_c) begin
                    err <= 1'b1;
                    sc  <= DEF_SC;
                    ec  <= DEF_EC;
                  end else begin
                    sc <= COORD_W'(arg_start_c);
                    ec <= COORD_W'(arg_end_c);
                  end
                end else begin
                  if (row_bad_c) begin
                    err <= 1'b1;
                    sp  <= DEF_SP;
                    ep  <= DEF_EP;
                  end else begin
                    sp <= COORD_W'(arg_start_c);
                    ep <= COORD_W'(arg_end_c);
                  end
                end
              end
            end
            ST_RAMWR_DATA: begin
              if (!have_hi) begin
                hi_byte <= byte_data;
                have_hi <= 1'b1;
              end else begin
                have_hi     <= 1'b0;
                pixel_valid <= 1'b1;
                pixel_x     <= cx;
                pixel_y     <= cy;
                pixel_data  <= PIXEL_SIZE'({hi_byte, byte_data});
                if (cx == ec) begin
                  cx <= sc;
                  if (cy == ep) begin
                    cy         <= sp;
                    frame_done <= 1'b1;
                  end else begin
                    cy <= cy + 9'd1;
                  end
                end else begin
                  cx <= cx + 9'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.cmd_valid   = cmd_valid;
  assign bus.cmd_byte    = cmd_byte;
  assign bus.pixel_valid = pixel_valid;
  assign bus.pixel_x     = pixel_x;
  assign bus.pixel_y     = pixel_y;
  assign bus.pixel_data  = pixel_data;
  assign bus.frame_done  = frame_done;
  assign bus.err         = err;

endmodule

// File: tb/tb_ili9341_spi_receiver.sv
// Self-checking bench for ili9341_spi_receiver on a reduced 16x10 panel.
module tb_ili9341_spi_receiver;
  import ili9341_pkg::*;

  localparam int unsigned H = 16;
  localparam int unsigned V = 10;
  localparam int P = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ili9341_spi_receiver_if #(.PIXEL_SIZE(16)) bus();

  ili9341_spi_receiver #(.H_RES(H), .V_RES(V), .PIXEL_SIZE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #(P/2) clk = ~clk;

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
    logic        fd;
  } pix_t;

  pix_t       got_pix[$];
  pix_t       exp_pix[$];
  logic [7:0] got_cmd[$];
  logic [7:0] exp_cmd[$];
  int         stray_fd = 0;
  time        t_last_rise = 0;
  time        t_pix = 0;
  time        t_cmd = 0;

  int checks = 0;
  int failures = 0;

  // Output monitor sampling away from the active edge.
  always @(negedge clk) begin
    if (bus.pixel_valid) begin
      got_pix.push_back(pix_t'{bus.pixel_x, bus.pixel_y, bus.pixel_data, bus.frame_done});
      t_pix = $time;
    end
    if (bus.frame_done && !bus.pixel_valid) stray_fd++;
    if (bus.cmd_valid) begin
      got_cmd.push_back(bus.cmd_byte);
      t_cmd = $time;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: window plus linear pixel index within the current RAMWR burst.
  int  m_mode;
  int  m_args[$];
  int  m_hi;
  int  m_sc, m_ec, m_sp, m_ep, m_n;
  bit  m_err;

  task automatic model_reset();
    m_mode = 0; m_args.delete(); m_hi = -1;
    m_sc = 0; m_ec = int'(H) - 1; m_sp = 0; m_ep = int'(V) - 1;
    m_n = 0; m_err = 1'b0;
  endtask

  task automatic model_byte(input bit dc, input int b);
    int s, e, lim, w, h, k;
    if (!dc) begin
      exp_cmd.push_back(8'(b));
      m_args.delete();
      m_hi = -1;
      case (b)
        'h2A: m_mode = 1;
        'h2B: m_mode = 2;
        'h2C: begin m_mode = 3; m_n = 0; end
        'h01: begin
          m_mode = 0; m_sc = 0; m_ec = int'(H) - 1; m_sp = 0; m_ep = int'(V) - 1; m_err = 1'b0;
        end
        default: m_mode = 4;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_args.push_back(b);
      if (m_args.size() == 4) begin
        s = m_args[0] * 256 + m_args[1];
        e = m_args[2] * 256 + m_args[3];
        lim = (m_mode == 1) ? int'(H) : int'(V);
        if (s > e || e >= lim) begin m_err = 1'b1; s = 0; e = lim - 1; end
        if (m_mode == 1) begin m_sc = s; m_ec = e; end
        else begin m_sp = s; m_ep = e; end
        m_args.delete();
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (m_hi < 0) m_hi = b;
      else begin
        w = m_ec - m_sc + 1;
        h = m_ep - m_sp + 1;
        k = m_n % (w * h);
        exp_pix.push_back(pix_t'{9'(m_sc + k % w), 9'(m_sp + k / w), 16'(m_hi * 256 + b),
                                 1'(k == w * h - 1)});
        m_n++;
        m_hi = -1;
      end
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input bit dc, input logic [7:0] b, input int n);
    bus.spi_cs = 1'b0;
    bus.spi_dc = dc;
    for (int i = 0; i < n; i++) begin
      bus.spi_mosi = b[7-i];
      clk_wait(3);
      bus.spi_sck = 1'b1;
      t_last_rise = $time;
      clk_wait(3);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input bit dc, input int b);
    send_bits(dc, 8'(b), 8);
    model_byte(dc, b);
  endtask

  task automatic cs_break();
    clk_wait(3);
    bus.spi_cs = 1'b1;
    clk_wait(4);
    m_hi = -1;
  endtask

  task automatic send_window(input int cmd, input int s, input int e);
    send_byte(1'b0, cmd);
    send_byte(1'b1, s / 256);
    send_byte(1'b1, s % 256);
    send_byte(1'b1, e / 256);
    send_byte(1'b1, e % 256);
  endtask

  task automatic drain(input string name);
    int n;
    clk_wait(8);
    check({name, "_npix"}, 64'(got_pix.size()), 64'(exp_pix.size()));
    n = (got_pix.size() < exp_pix.size()) ? got_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++) check({name, "_pix"}, 64'(got_pix[i]), 64'(exp_pix[i]));
    check({name, "_ncmd"}, 64'(got_cmd.size()), 64'(exp_cmd.size()));
    n = (got_cmd.size() < exp_cmd.size()) ? got_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) check({name, "_cmd"}, 64'(got_cmd[i]), 64'(exp_cmd[i]));
    check({name, "_err"}, 64'(bus.err), 64'(m_err));
    got_pix.delete(); exp_pix.delete(); got_cmd.delete(); exp_cmd.delete();
  endtask

  typedef struct {
    int cs, ce, ps, pe;
    bit err;
    int x0, y0; bit fd0;
    int x1, y1; bit fd1;
  } win_vec_t;

  initial begin
    win_vec_t    tbl[5];
    logic [15:0] d0, d1;
    int          xs[6], ys[6];
    int          fd_cnt, r, r2, dv;

    bus.spi_cs = 1'b1; bus.spi_sck = 1'b0; bus.spi_mosi = 1'b0; bus.spi_dc = 1'b0;
    model_reset();
    clk_wait(5);
    check("rst_pixel_valid", 64'(bus.pixel_valid), 0);
    check("rst_cmd_valid",   64'(bus.cmd_valid), 0);
    check("rst_cmd_byte",    64'(bus.cmd_byte), 0);
    check("rst_pixel_x",     64'(bus.pixel_x), 0);
    check("rst_pixel_y",     64'(bus.pixel_y), 0);
    check("rst_pixel_data",  64'(bus.pixel_data), 0);
    check("rst_frame_done",  64'(bus.frame_done), 0);
    check("rst_err",         64'(bus.err), 0);
    rst = 1'b1;
    clk_wait(2);

    // First RAMWR pixel and pipeline latency.
    send_byte(1'b0, 'h2C);
    clk_wait(3);
    check("cmd_latency", 64'(t_cmd - t_last_rise), 64'(4 * P + P / 2 - 1));
    send_byte(1'b1, 'hF8);
    send_byte(1'b1, 'h00);
    clk_wait(3);
    check("pix_latency", 64'(t_pix - t_last_rise), 64'(4 * P + P / 2 - 1));
    check("first_npix", 64'(got_pix.size()), 1);
    if (got_pix.size() > 0)
      check("first_pix", 64'(got_pix[0]), 64'({9'd0, 9'd0, 16'hF800, 1'b0}));
    if (got_cmd.size() > 0) check("first_cmd", 64'(got_cmd[0]), 64'h2C);
    drain("first");

    // Small window walk with frame wrap on the last pixel.
    send_window('h2A, 10, 12);
    send_window('h2B, 5, 6);
    send_byte(1'b0, 'h2C);
    for (int i = 0; i < 6; i++) begin
      send_byte(1'b1, $urandom_range(0, 255));
      send_byte(1'b1, $urandom_range(0, 255));
    end
    clk_wait(6);
    xs = '{10, 11, 12, 10, 11, 12};
    ys = '{5, 5, 5, 6, 6, 6};
    check("win6_npix", 64'(got_pix.size()), 6);
    if (got_pix.size() == 6)
      for (int i = 0; i < 6; i++)
        check("win6_xyfd", 64'({got_pix[i].x, got_pix[i].y, got_pix[i].fd}),
              64'({9'(xs[i]), 9'(ys[i]), 1'(i == 5)}));
    drain("win6");

    // Window legality table on the 16x10 panel.
    tbl[0] = '{2, 5, 3, 4,     1'b0, 2, 3, 1'b0, 3, 3, 1'b0};
    tbl[1] = '{20, 10, 1, 2,   1'b1, 0, 1, 1'b0, 1, 1, 1'b0};
    tbl[2] = '{5, 16, 0, 9,    1'b1, 0, 0, 1'b0, 1, 0, 1'b0};
    tbl[3] = '{15, 15, 9, 9,   1'b0, 15, 9, 1'b1, 15, 9, 1'b1};
    tbl[4] = '{256, 256, 0, 0, 1'b1, 0, 0, 1'b0, 1, 0, 1'b0};
    for (int t = 0; t < 5; t++) begin
      send_byte(1'b0, 'h01);
      send_window('h2A, tbl[t].cs, tbl[t].ce);
      send_window('h2B, tbl[t].ps, tbl[t].pe);
      d0 = 16'($urandom); d1 = 16'($urandom);
      send_byte(1'b0, 'h2C);
      send_byte(1'b1, int'(d0[15:8])); send_byte(1'b1, int'(d0[7:0]));
      send_byte(1'b1, int'(d1[15:8])); send_byte(1'b1, int'(d1[7:0]));
      clk_wait(6);
      check("tbl_err", 64'(bus.err), 64'(tbl[t].err));
      check("tbl_npix", 64'(got_pix.size()), 2);
      if (got_pix.size() == 2) begin
        check("tbl_pix0", 64'(got_pix[0]), 64'({9'(tbl[t].x0), 9'(tbl[t].y0), d0, tbl[t].fd0}));
        check("tbl_pix1", 64'(got_pix[1]), 64'({9'(tbl[t].x1), 9'(tbl[t].y1), d1, tbl[t].fd1}));
      end
      drain("tbl");
      send_byte(1'b0, 'h01);
      clk_wait(6);
      check("tbl_swreset_err", 64'(bus.err), 0);
      drain("tbl_sw");
    end

    // Partial byte discarded by deselect, then one clean pixel.
    send_bits(1'b0, 8'h2A, 5);
    cs_break();
    send_byte(1'b0, 'h2C);
    send_byte(1'b1, 'h12);
    send_byte(1'b1, 'h34);
    clk_wait(6);
    check("partial_npix", 64'(got_pix.size()), 1);
    if (got_pix.size() == 1) check("partial_data", 64'(got_pix[0].d), 64'h1234);
    drain("partial");

    // Deselect after the high byte: the next two bytes form the pixel at the same cursor.
    send_byte(1'b0, 'h2C);
    send_byte(1'b1, 'hAA);
    cs_break();
    send_byte(1'b1, 'h56);
    send_byte(1'b1, 'h78);
    drain("cs_mid");

    // Unknown command after the high byte aborts the pixel and skips data.
    send_byte(1'b0, 'h2C);
    send_byte(1'b1, 'hAB);
    send_byte(1'b0, 'h00);
    send_byte(1'b1, 'hCD);
    send_byte(1'b1, 'hEF);
    clk_wait(6);
    check("skip_npix", 64'(got_pix.size()), 0);
    drain("skip");

    // Reset landing between the final sck rise and the pixel pulse.
    send_byte(1'b0, 'h2C);
    send_byte(1'b1, 'h11);
    drain("pre_rst");
    send_bits(1'b1, 8'h22, 7);
    bus.spi_mosi = 1'b0;
    clk_wait(3);
    bus.spi_sck = 1'b1;
    clk_wait(1);
    rst = 1'b0;
    clk_wait(4);
    bus.spi_sck = 1'b0;
    bus.spi_cs = 1'b1;
    clk_wait(2);
    rst = 1'b1;
    model_reset();
    clk_wait(10);
    check("rst_mid_npix", 64'(got_pix.size()), 0);
    check("rst_mid_pixel_x", 64'(bus.pixel_x), 0);
    drain("rst_mid");

    // Full default frame.
    send_byte(1'b0, 'h01);
    send_byte(1'b0, 'h2C);
    for (int i = 0; i < int'(H * V); i++) begin
      send_byte(1'b1, $urandom_range(0, 255));
      send_byte(1'b1, $urandom_range(0, 255));
    end
    clk_wait(6);
    fd_cnt = 0;
    foreach (got_pix[i]) if (got_pix[i].fd) fd_cnt++;
    check("frame_npix", 64'(got_pix.size()), 64'(H * V));
    check("frame_fd_cnt", 64'(fd_cnt), 1);
    if (got_pix.size() > 0)
      check("frame_last", 64'({got_pix[got_pix.size()-1].x, got_pix[got_pix.size()-1].y,
                              got_pix[got_pix.size()-1].fd}), 64'({9'(H-1), 9'(V-1), 1'b1}));
    drain("frame");

    // Random command/data/deselect mix against the model.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12) begin
        r2 = $urandom_range(0, 5);
        case (r2)
          0: dv = 'h2A;
          1: dv = 'h2B;
          2: dv = 'h2C;
          3: dv = 'h01;
          4: dv = 'h2C;
          default: dv = $urandom_range(0, 255);
        endcase
        send_byte(1'b0, dv);
      end else if (r < 16) begin
        send_bits($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 7));
        cs_break();
      end else begin
        r2 = $urandom_range(0, 99);
        if (r2 < 40) dv = 0;
        else if (r2 < 85) dv = $urandom_range(0, 17);
        else dv = $urandom_range(0, 255);
        send_byte(1'b1, dv);
      end
    end
    drain("rand");

    check("stray_frame_done", 64'(stray_fd), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ili9341_spi_receiver.md
# ili9341_spi_receiver

Display-side decoder for the ILI9341 4-wire SPI stream that the panel controller emits. It samples spi_sck/spi_mosi/spi_cs/spi_dc in the system clock domain, assembles bytes, and interprets CASET/PASET/RAMWR/SWRESET. It emits one addressed pixel write per received 16-bit RGB565 word. It sits beside the panel as a frame-capture/mirror front end and as the checker endpoint in loopback benches of the transmit path.

## Interface
- H_RES, 240: panel columns; default column window end = H_RES-1.
- V_RES, 320: panel rows; default page window end = V_RES-1.
- PIXEL_SIZE, 16: pixel width, sent as two bytes, high byte first.

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- spi_sck  in  1  SPI clock, asynchronous to clk, mode 0.
- spi_mosi  in  1  serial data, MSB first.
- spi_cs  in  1  chip select, active-low.
- spi_dc  in  1  0 = command byte, 1 = data byte.
- cmd_valid  out  1  one-cycle pulse per command byte received.
- cmd_byte  out  8  last command byte.
- pixel_valid  out  1  one-cycle pulse per completed pixel.
- pixel_x  out  9  column of the current pixel.
- pixel_y  out  9  row of the current pixel.
- pixel_data  out  PIXEL_SIZE  RGB565 value.
- frame_done  out  1  one-cycle pulse with the pixel written at (EC, EP).
- err  out  1  sticky flag for an illegal window; cleared by reset or SWRESET.

## Operation
- Input sync: 2-flop synchronizers on all four SPI inputs; rising-edge detect on synced sck.
- Byte assembly runs only while synced cs = 0:
  - On each detected sck rise, shift mosi into a shift register.
  - On the 8th bit, produce byte_valid with dc sampled at that same edge.
  - cs = 1 clears the bit counter; a partial byte is discarded silently.
- Decoder FSM states: IDLE, CASET_ARG, PASET_ARG, RAMWR_DATA, SKIP.
- Any byte with dc = 0:
  - Pulses cmd_valid and loads cmd_byte.
  - Aborts the current state and the argument/pixel byte index.
  - Next state: 0x2A -> CASET_ARG, 0x2B -> PASET_ARG, 0x2C -> RAMWR_DATA, 0x01 -> IDLE with window restored to default and err cleared, anything else -> SKIP.
- CASET_ARG / PASET_ARG:
  - Take 4 data bytes {start_hi, start_lo, end_hi, end_lo}, then go to IDLE.
  - Window regs update only after all 4 bytes arrive; a truncated sequence leaves them unchanged.
  - If start > end or end >= H_RES (resp. V_RES): set err and load the full default window for that axis.
- RAMWR_DATA:
  - Entry sets cursor x = SC, y = SP.
  - Byte 0 is the high byte, byte 1 the low byte. On the low byte, pulse pixel_valid with the current cursor.
  - Cursor advance: x++. If x == EC, x wraps to SC and y++. If additionally y == EP, y wraps to SP and frame_done pulses with that pixel.
  - Writing continues past wrap (the next frame overwrites).
- Data bytes in IDLE or SKIP are ignored.
- Reset state:
  - All outputs 0.
  - FSM in IDLE.
  - Window SC=0, EC=H_RES-1, SP=0, EP=V_RES-1.
  - Shift register and counters cleared; cursor 0.

## Timing
- Latency: pixel_valid/cmd_valid assert exactly 4 clk after the clk edge at which raw spi_sck rises for the final bit (2 sync + edge detect + register).
- Outputs are registered. pixel_x/pixel_y/pixel_data hold their value until the next pixel.
- Requirements on the SPI source:
  - Each SPI clock half-period >= 3 clk.
  - cs setup before the first sck rise >= 3 clk.
  - dc stable from the 1st to the 8th sck rise of each byte.
- cs deassert mid-pixel (after the high byte) drops that high byte. RAMWR state and cursor persist, so the next two data bytes form a pixel at the same cursor.
- Reset mid-frame: takes effect at the next clk edge; no pending pulse is emitted.

## Structure
- Package ili9341_pkg holds:
  - Command constants CMD_SWRESET=8'h01, CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C.
  - FSM state encoding.
  - Default window constants.
- Sub-module ili9341_spi_byte_rx contains the synchronizers, edge detect and shift register. Its outputs are byte_valid, byte_data[7:0] and byte_dc.
- Top file holds the decoder FSM, window regs and cursor.

## Test plan
- Reset, then RAMWR + 2 bytes 0xF8,0x00 -> pixel_valid once, x=0, y=0, data=16'hF800; cmd_valid once with cmd_byte=8'h2C.
- CASET 0,10,0,12; PASET 0,5,0,6; RAMWR + 6 pixels -> coords (10,5),(11,5),(12,5),(10,6),(11,6),(12,6); frame_done only with the 6th pixel.
- CASET 0,20,0,10 (start>end) -> err=1, column window 0..H_RES-1; then SWRESET -> err=0.
- cs high after 5 bits, then a full RAMWR pixel sequence -> the partial byte is ignored; exactly one pixel_valid, with correct data.
- During RAMWR, send command 0x00 after the high byte -> no pixel_valid; following data bytes are ignored (SKIP).
- Full 240x320 default frame at sck = clk/6 -> 76800 pixel_valid pulses, one frame_done, last pixel (239,319).
